// File: rtl/proximity_regfile_arbiter_if.sv
// Host-side and register-file-side signals of the proximity register-file arbiter.
// The arbiter connects through the slave modport; the surrounding logic drives the master side.
interface proximity_regfile_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_err;

  logic                  reg_write;
  logic                  reg_read;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic [DATA_WIDTH-1:0] reg_rdata;
  logic                  reg_ready;
  logic                  reg_error;

  logic                  busy;
  logic                  grant_id;
  logic                  timeout_pulse;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  reg_rdata, reg_ready, reg_error,
    output m0_ack, m0_rdata, m0_err,
    output m1_ack, m1_rdata, m1_err,
    output reg_write, reg_read, reg_addr, reg_wdata,
    output busy, grant_id, timeout_pulse
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output reg_rdata, reg_ready, reg_error,
    input  m0_ack, m0_rdata, m0_err,
    input  m1_ack, m1_rdata, m1_err,
    input  reg_write, reg_read, reg_addr, reg_wdata,
    input  busy, grant_id, timeout_pulse
  );
endinterface

// File: rtl/proximity_regfile_arbiter.sv
// Round-robin arbiter sharing one register-file port between a host and a config sequencer,
// with a bounded wait on the register file and fully registered outputs.
module proximity_regfile_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  proximity_regfile_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                state;
  state_t                next_state;
  logic [7:0]            wait_cnt;
  logic                  last_grant;
  logic                  latch;
  logic                  winner;
  logic                  done;
  logic                  timed_out;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    latch      = 1'b0;
    winner     = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          latch      = 1'b1;
          next_state = S_ISSUE;
          // Under contention the master not served last time wins.
          if (bus.m0_req && bus.m1_req) winner = ~last_grant;
          else                          winner = bus.m1_req;
        end
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT: begin
        if (bus.reg_ready) begin
          done       = 1'b1;
          next_state = S_RESP;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          done       = 1'b1;
          timed_out  = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign win_we    = winner ? bus.m1_we    : bus.m0_we;
  assign win_addr  = winner ? bus.m1_addr  : bus.m0_addr;
  assign win_wdata = winner ? bus.m1_wdata : bus.m0_wdata;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Outputs are set on the edge that enters the state they belong to, so they line up with that state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.reg_write     <= 1'b0;
      bus.reg_read      <= 1'b0;
      bus.reg_addr      <= '0;
      bus.reg_wdata     <= '0;
      bus.m0_ack        <= 1'b0;
      bus.m0_rdata      <= '0;
      bus.m0_err        <= 1'b0;
      bus.m1_ack        <= 1'b0;
      bus.m1_rdata      <= '0;
      bus.m1_err        <= 1'b0;
      bus.busy          <= 1'b0;
      bus.grant_id      <= 1'b0;
      bus.timeout_pulse <= 1'b0;
      wait_cnt          <= '0;
      last_grant        <= 1'b1;
    end else begin
      bus.reg_write     <= 1'b0;
      bus.reg_read      <= 1'b0;
      bus.m0_ack        <= 1'b0;
      bus.m1_ack        <= 1'b0;
      bus.timeout_pulse <= 1'b0;
      bus.busy          <= (next_state != S_IDLE);

      if (latch) begin
        bus.grant_id  <= winner;
        bus.reg_addr  <= win_addr;
        bus.reg_wdata <= win_wdata;
        bus.reg_write <= win_we;
        bus.reg_read  <= ~win_we;
      end

      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT && !bus.reg_ready && !timed_out) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (done) begin
        bus.timeout_pulse <= timed_out;
        if (bus.grant_id) begin
          bus.m1_ack   <= 1'b1;
          bus.m1_rdata <= timed_out ? '0 : bus.reg_rdata;
          bus.m1_err   <= timed_out | bus.reg_error;
        end else begin
          bus.m0_ack   <= 1'b1;
          bus.m0_rdata <= timed_out ? '0 : bus.reg_rdata;
          bus.m0_err   <= timed_out | bus.reg_error;
        end
      end

      if (state == S_RESP) last_grant <= bus.grant_id;
    end
  end

endmodule

// File: tb/tb_proximity_regfile_arbiter.sv
// Directed bench for proximity_regfile_arbiter: a small register-file responder plus
// one task per scenario, each comparing outputs against hand-computed values.
module tb_proximity_regfile_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit          rf_hang  = 1'b0;
  bit          rf_err   = 1'b0;
  bit          rf_stray = 1'b0;
  bit          pend     = 1'b0;
  logic [31:0] pend_data = '0;
  logic [31:0] mem [64];

  proximity_regfile_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  proximity_regfile_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register file: answers one cycle after a strobe unless told to hang.
  initial begin
    bus.reg_ready = 1'b0;
    bus.reg_error = 1'b0;
    bus.reg_rdata = '0;
    forever begin
      @(negedge clock);
      bus.reg_ready = pend || rf_stray;
      bus.reg_error = pend && rf_err;
      bus.reg_rdata = pend ? pend_data : 32'h0;
      pend = 1'b0;
      if ((bus.reg_read || bus.reg_write) && !rf_hang) begin
        pend = 1'b1;
        if (bus.reg_write) mem[bus.reg_addr] = bus.reg_wdata;
        pend_data = mem[bus.reg_addr];
      end
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic wait_ack(input int limit, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < limit) begin
      tick();
      cycles++;
      if (bus.m0_ack || bus.m1_ack) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.grant_id, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err,
         bus.reg_write, bus.reg_read, bus.timeout_pulse} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000000", {bus.busy, bus.grant_id, bus.m0_ack,
               bus.m1_ack, bus.m0_err, bus.m1_err, bus.reg_write, bus.reg_read, bus.timeout_pulse});
    end
    checks++;
    if ({bus.m0_rdata, bus.m1_rdata, bus.reg_addr, bus.reg_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected all zero",
               bus.m0_rdata, bus.m1_rdata, bus.reg_addr, bus.reg_wdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_single_read;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 6'h04; bus.m0_wdata = 32'h1111_1111;
    tick();
    checks++;
    if ({bus.reg_write, bus.reg_read} !== 2'b01) begin
      errors++;
      $display("FAIL read_strobe: got %b expected 01", {bus.reg_write, bus.reg_read});
    end
    checks++;
    if ({bus.busy, bus.grant_id, bus.reg_addr} !== {1'b1, 1'b0, 6'h04}) begin
      errors++;
      $display("FAIL read_issue: got busy=%b grant=%b addr=%h expected 1 0 04",
               bus.busy, bus.grant_id, bus.reg_addr);
    end
    bus.m0_addr = 6'h3F; bus.m0_we = 1'b1;
    tick();
    checks++;
    if ({bus.reg_write, bus.reg_read, bus.reg_addr} !== {2'b00, 6'h04}) begin
      errors++;
      $display("FAIL read_wait: got strobes=%b addr=%h expected 00 04",
               {bus.reg_write, bus.reg_read}, bus.reg_addr);
    end
    tick();
    checks++;
    if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m0_rdata} !== {3'b100, 32'h0000_0008}) begin
      errors++;
      $display("FAIL read_ack: got ack0=%b ack1=%b err=%b rdata=%h expected 1 0 0 00000008",
               bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    tick();
    checks++;
    if ({bus.m0_ack, bus.busy, bus.m0_rdata} !== {2'b00, 32'h0000_0008}) begin
      errors++;
      $display("FAIL read_done: got ack=%b busy=%b rdata=%h expected 0 0 00000008",
               bus.m0_ack, bus.busy, bus.m0_rdata);
    end
  endtask

  task automatic test_write_m1;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 6'h00; bus.m1_wdata = 32'h0000_0003;
    tick();
    checks++;
    if ({bus.reg_write, bus.reg_read, bus.grant_id, bus.reg_addr, bus.reg_wdata} !==
        {3'b101, 6'h00, 32'h0000_0003}) begin
      errors++;
      $display("FAIL write_issue: got w=%b r=%b grant=%b addr=%h wdata=%h expected 1 0 1 00 00000003",
               bus.reg_write, bus.reg_read, bus.grant_id, bus.reg_addr, bus.reg_wdata);
    end
    tick();
    checks++;
    if (bus.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL write_one_cycle: got %b expected 0", bus.reg_write);
    end
    tick();
    checks++;
    if ({bus.m1_ack, bus.m1_err, bus.m0_ack, bus.m0_rdata} !== {3'b100, 32'h0000_0008}) begin
      errors++;
      $display("FAIL write_ack: got ack1=%b err1=%b ack0=%b rdata0=%h expected 1 0 0 00000008",
               bus.m1_ack, bus.m1_err, bus.m0_ack, bus.m0_rdata);
    end
    bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_contention;
    int cyc;
    bit got;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 6'h04;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 6'h00;
    for (int i = 0; i < 4; i++) begin
      wait_ack(12, cyc, got);
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rr_ack_%0d: got no ack expected ack within 12 cycles", i);
      end else begin
        checks++;
        if ({bus.m0_ack, bus.m1_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_order_%0d: got acks=%b expected %b", i, {bus.m0_ack, bus.m1_ack},
                   (i % 2 == 0) ? 2'b10 : 2'b01);
        end
        checks++;
        if (((i % 2 == 0) ? bus.m0_rdata : bus.m1_rdata) !==
            ((i % 2 == 0) ? 32'h0000_0008 : 32'h0000_0003)) begin
          errors++;
          $display("FAIL rr_data_%0d: got %h %h", i, bus.m0_rdata, bus.m1_rdata);
        end
        if (i > 0) begin
          checks++;
          if (cyc != 4) begin
            errors++;
            $display("FAIL rr_spacing_%0d: got %0d cycles expected 4", i, cyc);
          end
        end
      end
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    int cyc;
    bit got;
    rf_hang = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 6'h04;
    tick();
    checks++;
    if (bus.reg_read !== 1'b1) begin
      errors++;
      $display("FAIL to_strobe: got %b expected 1", bus.reg_read);
    end
    wait_ack(30, cyc, got);
    checks++;
    if (!got || cyc != 17) begin
      errors++;
      $display("FAIL to_latency: got ack=%b after %0d cycles expected ack after 17", got, cyc);
    end
    checks++;
    if ({bus.timeout_pulse, bus.m0_ack, bus.m0_err, bus.m0_rdata} !== {3'b111, 32'h0}) begin
      errors++;
      $display("FAIL to_resp: got pulse=%b ack=%b err=%b rdata=%h expected 1 1 1 00000000",
               bus.timeout_pulse, bus.m0_ack, bus.m0_err, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.timeout_pulse} !== 2'b00) begin
      errors++;
      $display("FAIL to_idle: got busy=%b pulse=%b expected 0 0", bus.busy, bus.timeout_pulse);
    end
    rf_hang = 1'b0;
  endtask

  task automatic test_error;
    int cyc;
    bit got;
    rf_err = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 6'h3C;
    tick();
    wait_ack(10, cyc, got);
    checks++;
    if (!got || cyc != 2) begin
      errors++;
      $display("FAIL err_latency: got ack=%b after %0d cycles expected ack after 2", got, cyc);
    end
    checks++;
    if ({bus.m0_err, bus.timeout_pulse, bus.m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL err_resp: got err=%b pulse=%b rdata=%h expected 1 0 deadbeef",
               bus.m0_err, bus.timeout_pulse, bus.m0_rdata);
    end
    bus.m0_req = 1'b0;
    tick();
    rf_err = 1'b0;
  endtask

  task automatic test_stray_ready;
    rf_stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.busy, bus.m0_ack, bus.m1_ack, bus.m0_rdata} !== {3'b000, 32'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL stray_ready_%0d: got busy=%b acks=%b%b rdata0=%h expected 0 00 deadbeef",
                 i, bus.busy, bus.m0_ack, bus.m1_ack, bus.m0_rdata);
      end
    end
    rf_stray = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit got;
    rf_hang = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 6'h04;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.grant_id, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err,
         bus.reg_write, bus.reg_read, bus.timeout_pulse} !== 9'b0 ||
        {bus.m0_rdata, bus.m1_rdata, bus.reg_addr, bus.reg_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b ack0=%b err0=%b rdata0=%h addr=%h expected all zero",
               bus.busy, bus.m0_ack, bus.m0_err, bus.m0_rdata, bus.reg_addr);
    end
    bus.m0_req = 1'b0;
    tick();
    checks++;
    if ({bus.m0_ack, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_hold: got ack=%b busy=%b expected 0 0", bus.m0_ack, bus.busy);
    end
    reset = 1'b0;
    rf_hang = 1'b0;
    tick();
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 6'h04;
    wait_ack(10, cyc, got);
    checks++;
    if (!got || cyc != 3) begin
      errors++;
      $display("FAIL post_reset_latency: got ack=%b after %0d cycles expected ack after 3", got, cyc);
    end
    checks++;
    if ({bus.m1_ack, bus.m0_ack, bus.m1_err, bus.grant_id, bus.m1_rdata} !==
        {4'b1001, 32'h0000_0008}) begin
      errors++;
      $display("FAIL post_reset_resp: got ack1=%b ack0=%b err1=%b grant=%b rdata1=%h expected 1 0 0 1 00000008",
               bus.m1_ack, bus.m0_ack, bus.m1_err, bus.grant_id, bus.m1_rdata);
    end
    bus.m1_req = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b expected 0", bus.busy);
    end
  endtask

  initial begin
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    mem[6'h00] = 32'h0000_0000;
    mem[6'h04] = 32'h0000_0008;
    mem[6'h3C] = 32'hDEAD_BEEF;

    test_reset();
    test_single_read();
    test_write_m1();
    test_contention();
    test_timeout();
    test_error();
    test_stray_ready();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proximity_regfile_arbiter.md
PROXIMITY_REGFILE_ARBITER -- requirements
Module: proximity_regfile_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 6, register address width; DATA_WIDTH, default 32, data width; TIMEOUT, default 15, max WAIT cycles before abort (range 1-255).
REQ-002 SHALL have ports:
  clock  in  1  system clock
  reset  in  1  asynchronous, active-high reset
  m0_req  in  1  host request, held until m0_ack
  m0_we  in  1  host 1=write, 0=read
  m0_addr  in  ADDR_WIDTH  host address
  m0_wdata  in  DATA_WIDTH  host write data
  m0_ack  out  1  host completion pulse
  m0_rdata  out  DATA_WIDTH  host read data, valid with m0_ack
  m0_err  out  1  host error, valid with m0_ack
  m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata, m1_err  same as m0_*, for the on-chip config sequencer
  reg_write  out  1  register-file write strobe
  reg_read  out  1  register-file read strobe
  reg_addr  out  ADDR_WIDTH  register-file address
  reg_wdata  out  DATA_WIDTH  register-file write data
  reg_rdata  in  DATA_WIDTH  register-file read data
  reg_ready  in  1  register-file transaction done
  reg_error  in  1  register-file error, valid with reg_ready
  busy  out  1  1 when state != IDLE
  grant_id  out  1  master owning the current transaction
  timeout_pulse  out  1  one-cycle pulse on a timed-out transaction

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
REQ-004 IDLE: if any mX_req=1, SHALL latch the winner's we/addr/wdata, set grant_id and go to ISSUE; else stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: with both requests, grant the master not granted last; a sole requester wins regardless.
REQ-006 last-grant register SHALL reset to 1 so m0 wins the first contention.
REQ-007 ISSUE: SHALL assert exactly one of reg_write/reg_read for exactly one cycle, with reg_addr/reg_wdata from the latched request, then go to WAIT.
REQ-008 reg_addr/reg_wdata SHALL hold the latched values from ISSUE through RESP; strobes SHALL be 0 in every other state.
REQ-009 WAIT: on reg_ready=1, SHALL capture reg_rdata and reg_error and go to RESP.
REQ-010 WAIT: an 8-bit counter SHALL clear on entry and increment each cycle with reg_ready=0.
REQ-011 When the counter equals TIMEOUT with reg_ready=0, SHALL go to RESP with captured rdata=0, err=1, and pulse timeout_pulse for that cycle.
REQ-012 RESP: SHALL assert mX_ack of grant_id for one cycle with mX_rdata/mX_err = captured values, update last-grant, then go to IDLE.
REQ-013 Non-granted master's ack SHALL stay 0; its rdata/err SHALL hold their previous values.
REQ-014 Latency: req sampled in IDLE at cycle t -> strobe at t+1 -> ack at t+3 with a one-cycle-ready register file.
REQ-015 Requester SHALL drop req on the cycle after ack; a req still high in the following IDLE SHALL be treated as a new request.
REQ-016 Changes to request fields after IDLE latching SHALL NOT affect the transaction in flight.
REQ-017 reg_ready outside WAIT SHALL be ignored.
REQ-018 reg_error=1 with reg_ready SHALL propagate as mX_err=1 with captured rdata unchanged, and SHALL NOT pulse timeout_pulse.
REQ-019 busy SHALL be 1 in ISSUE, WAIT and RESP.

Reset
REQ-020 Reset asserted SHALL immediately force: state IDLE; all strobes, acks, errs, busy, timeout_pulse = 0; rdata/reg_addr/reg_wdata = 0; grant_id 0; counter 0; last-grant 1.
REQ-021 Reset mid-transaction SHALL abort with no ack; the first request after release SHALL go through normal arbitration.

Verification
REQ-022 Single m0 read of addr 0x04, regfile returns 0x00000008 -> reg_read pulse at t+1, m0_ack at t+3, m0_rdata=0x00000008, m0_err=0.
REQ-023 m0 and m1 request in the same cycle after reset -> m0 served first, then m1; alternating grants hold with both requests kept high.
REQ-024 m1 write 0x00000003 to 0x00 -> one-cycle reg_write, reg_wdata=0x00000003, m1_ack with m1_err=0, m0_ack stays 0.
REQ-025 reg_ready held 0 with TIMEOUT=15 -> timeout_pulse after 15 WAIT cycles, then ack with rdata=0, err=1; busy returns to 0.
REQ-026 Regfile returns reg_error=1 with rdata 0xDEADBEEF (address 0x3C) -> ack with err=1, rdata=0xDEADBEEF, no timeout_pulse.
REQ-027 Reset asserted in WAIT -> all outputs at reset values, no ack; a new m1 request after release completes normally.
